arm7tdmi_operand2_unit: RTL and testbench

- Data-processing operand-2 stage between register-file read and ALU: decodes the 12-bit shifter_operand field, sequences the extra internal cycle for register-specified shifts, and produces the final operand plus shifter carry-out.
- Implements the full ARM shift semantics, including amounts 0 and 32 and above, LSR/ASR #0 meaning 32, RRX and immediate rotate.
- Valid/ready on both sides; output is registered.

---
 rtl/arm7tdmi_operand2_unit.sv | 192 +++++++++++++++++++
 tb/tb_arm7tdmi_operand2_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/arm7tdmi_operand2_unit.sv
// arm7tdmi_operand2_unit
//
// Operand-2 stage of the data-processing datapath. It sits between the
// register-file read and the ALU. It decodes the 12-bit shifter_operand field
// and applies the full ARM barrel-shifter semantics: rotated immediate,
// immediate shift (including LSR/ASR #0 = #32 and ROR #0 = RRX) and
// register-specified shift. A register shift needs one extra internal cycle
// so that Rs[7:0] can be fetched.
//
// Ports:
//   clk, rst           core clock, synchronous active-high reset
//   in_valid/in_ready  request handshake
//   in_imm, in_op2     instruction I bit and bits [11:0]
//   in_rm, in_cflag    Rm value and CPSR C, sampled on accept
//   rs_rd_en, rs_data  Rs read request pulse; Rs[7:0] returns the next cycle
//   out_valid/out_ready result handshake (result is registered)
//   out_operand        shifted/rotated operand 2
//   out_carry          shifter carry-out
//
// Optional build macro ARM7TDMI_OPERAND2_ICYCLE_CNT_EN adds the outputs
// icycle_cnt[15:0] and icycle_pulse. These count and flag the internal cycles
// spent waiting for Rs.

module arm7tdmi_operand2_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_imm,
  input  logic [11:0]       in_op2,
  input  logic [DATA_W-1:0] in_rm,
  input  logic              in_cflag,
  output logic              rs_rd_en,
  input  logic [7:0]        rs_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_operand,
  output logic              out_carry
`ifdef ARM7TDMI_OPERAND2_ICYCLE_CNT_EN
  ,
  output logic [15:0]       icycle_cnt,
  output logic              icycle_pulse
`endif
);

  typedef enum logic [1:0] {IDLE, RSWAIT, HOLD} state_t;

  state_t      state, next_state;
  logic [31:0] rm_q;
  logic        c_q;
  logic [1:0]  type_q;
  logic        accept, is_reg_shift, load_res, latch_req;
  logic [32:0] new_res, reg_res, res;

  // Generic shifter. The returned value is {carry, result}. amt is treated at
  // full 8-bit width, so only ROR reduces it modulo 32.
  function automatic logic [32:0] shift_op(input logic [1:0] typ, input logic [31:0] rm,
                                           input logic c, input logic [7:0] amt);
    logic [32:0] t;
    logic [31:0] r;
    logic [4:0]  ra;
    t  = '0;
    r  = '0;
    ra = amt[4:0];
    shift_op = {c, rm};
    if (amt != 8'd0) begin
      case (typ)
        2'b00: begin
          if (amt <= 8'd32) begin
            t = {1'b0, rm} << amt;
            shift_op = t;
          end else shift_op = '0;
        end
        2'b01: begin
          if (amt <= 8'd32) begin
            t = {rm, 1'b0} >> amt;
            shift_op = {t[0], t[32:1]};
          end else shift_op = '0;
        end
        2'b10: begin
          if (amt >= 8'd32) shift_op = {rm[31], {32{rm[31]}}};
          else begin
            t = $signed({rm, 1'b0}) >>> amt;
            shift_op = {t[0], t[32:1]};
          end
        end
        default: begin
          if (ra == 5'd0) shift_op = {rm[31], rm};
          else begin
            r = (rm >> ra) | (rm << (6'd32 - {1'b0, ra}));
            shift_op = {r[31], r};
          end
        end
      endcase
    end
  endfunction

  // Rotated 8-bit immediate. Carry only changes when the rotate is non-zero.
  function automatic logic [32:0] imm_op(input logic [11:0] op2, input logic c);
    logic [4:0]  rot2;
    logic [31:0] imm, r;
    rot2 = {op2[11:8], 1'b0};
    imm  = {24'd0, op2[7:0]};
    r    = (imm >> rot2) | (imm << (6'd32 - {1'b0, rot2}));
    imm_op = {(op2[11:8] != 4'd0) ? r[31] : c, r};
  endfunction

  // Immediate-amount shift. An amount of 0 encodes LSR/ASR #32 and RRX.
  function automatic logic [32:0] imm_shift_op(input logic [11:0] op2, input logic [31:0] rm,
                                               input logic c);
    logic [4:0] amt5;
    amt5 = op2[11:7];
    if (amt5 != 5'd0) imm_shift_op = shift_op(op2[6:5], rm, c, {3'd0, amt5});
    else begin
      case (op2[6:5])
        2'b00:   imm_shift_op = {c, rm};
        2'b11:   imm_shift_op = {rm[0], c, rm[31:1]};
        default: imm_shift_op = shift_op(op2[6:5], rm, c, 8'd32);
      endcase
    end
  endfunction

  assign in_ready     = (state == IDLE) || ((state == HOLD) && out_ready);
  assign accept       = in_valid && in_ready && !rst;
  assign is_reg_shift = !in_imm && in_op2[4];
  assign out_valid    = (state == HOLD);
  assign new_res      = in_imm ? imm_op(in_op2, in_cflag) : imm_shift_op(in_op2, in_rm, in_cflag);
  assign reg_res      = shift_op(type_q, rm_q, c_q, rs_data);

  // Next-state logic. Accepts happen only in IDLE or HOLD, so the accept
  // block below never competes with the RSWAIT completion.
  always_comb begin
    next_state = state;
    load_res   = 1'b0;
    latch_req  = 1'b0;
    rs_rd_en   = 1'b0;
    res        = new_res;
    case (state)
      RSWAIT: begin
        res        = reg_res;
        load_res   = 1'b1;
        next_state = HOLD;
      end
      HOLD: if (out_ready) next_state = IDLE;
      default: ;
    endcase
    if (accept) begin
      if (is_reg_shift) begin
        latch_req  = 1'b1;
        rs_rd_en   = 1'b1;
        next_state = RSWAIT;
      end else begin
        load_res   = 1'b1;
        next_state = HOLD;
      end
    end
  end

  // State, result and latched register-shift request. Reset drops any
  // in-flight request without producing a result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      out_operand <= '0;
      out_carry   <= 1'b0;
      rm_q        <= '0;
      c_q         <= 1'b0;
      type_q      <= 2'b00;
    end else begin
      state <= next_state;
      if (load_res) {out_carry, out_operand} <= res;
      if (latch_req) begin
        rm_q   <= in_rm;
        c_q    <= in_cflag;
        type_q <= in_op2[6:5];
      end
    end
  end

`ifdef ARM7TDMI_OPERAND2_ICYCLE_CNT_EN
  // Counts the internal cycles spent waiting for Rs. The count wraps at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) icycle_cnt <= '0;
    else if (state == RSWAIT) icycle_cnt <= icycle_cnt + 16'd1;
  end

  assign icycle_pulse = (state == RSWAIT);
`endif

endmodule

// File: tb/tb_arm7tdmi_operand2_unit.sv
// tb_arm7tdmi_operand2_unit
//
// Directed bench for arm7tdmi_operand2_unit. It applies hand-computed vectors
// for the immediate, immediate-shift and register-shift paths, back-pressure
// and back-to-back handoff, and reset while a register shift is waiting for Rs.

module tb_arm7tdmi_operand2_unit;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_imm, in_cflag, rs_rd_en;
  logic [11:0] in_op2;
  logic [31:0] in_rm, out_operand;
  logic [7:0]  rs_data;
  logic        out_valid, out_ready, out_carry;
`ifdef ARM7TDMI_OPERAND2_ICYCLE_CNT_EN
  logic [15:0] icycle_cnt;
  logic        icycle_pulse;
`endif

  int vec_cnt  = 0;
  int miss_cnt = 0;

  arm7tdmi_operand2_unit #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_imm(in_imm), .in_op2(in_op2), .in_rm(in_rm), .in_cflag(in_cflag),
    .rs_rd_en(rs_rd_en), .rs_data(rs_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_operand(out_operand), .out_carry(out_carry)
`ifdef ARM7TDMI_OPERAND2_ICYCLE_CNT_EN
    , .icycle_cnt(icycle_cnt), .icycle_pulse(icycle_pulse)
`endif
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic imm, input logic [11:0] op2, input logic [31:0] rm,
                           input logic c);
    in_valid = 1'b1;
    in_imm   = imm;
    in_op2   = op2;
    in_rm    = rm;
    in_cflag = c;
    #1;
  endtask

  // Immediate-style request. This task returns one cycle after the accept.
  task automatic issue_imm(input logic imm, input logic [11:0] op2, input logic [31:0] rm,
                           input logic c);
    drive_req(imm, op2, rm, c);
    tick();
    in_valid = 1'b0;
  endtask

  // Register-shift request. This task returns two cycles after the accept.
  task automatic issue_reg(input logic [11:0] op2, input logic [31:0] rm, input logic c,
                           input logic [7:0] rs);
    drive_req(1'b0, op2, rm, c);
    tick();
    in_valid = 1'b0;
    rs_data  = rs;
    tick();
    rs_data  = 8'h00;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    vec_cnt++; if (out_valid !== 1'b0) begin miss_cnt++; $display("[TB] FAIL reset_valid got %b exp 0", out_valid); end
    vec_cnt++; if (out_operand !== 32'h0) begin miss_cnt++; $display("[TB] FAIL reset_operand got %h exp 0", out_operand); end
    vec_cnt++; if (out_carry !== 1'b0) begin miss_cnt++; $display("[TB] FAIL reset_carry got %b exp 0", out_carry); end
    vec_cnt++; if (in_ready !== 1'b1) begin miss_cnt++; $display("[TB] FAIL reset_ready got %b exp 1", in_ready); end
    vec_cnt++; if (rs_rd_en !== 1'b0) begin miss_cnt++; $display("[TB] FAIL reset_rsrd got %b exp 0", rs_rd_en); end
  endtask

  task automatic test_immediate();
    logic [11:0] op2 [3]  = '{12'h4FF, 12'h103, 12'h0AB};
    logic        c   [3]  = '{1'b0, 1'b0, 1'b1};
    logic [31:0] eo  [3]  = '{32'hFF000000, 32'hC0000000, 32'h000000AB};
    logic        ec  [3]  = '{1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      issue_imm(1'b1, op2[i], 32'hDEADBEEF, c[i]);
      vec_cnt++; if (out_valid !== 1'b1) begin miss_cnt++; $display("[TB] FAIL imm_valid[%0d] got %b exp 1", i, out_valid); end
      vec_cnt++; if (out_operand !== eo[i]) begin miss_cnt++; $display("[TB] FAIL imm_operand[%0d] got %h exp %h", i, out_operand, eo[i]); end
      vec_cnt++; if (out_carry !== ec[i]) begin miss_cnt++; $display("[TB] FAIL imm_carry[%0d] got %b exp %b", i, out_carry, ec[i]); end
      drain();
    end
  endtask

  task automatic test_imm_shift();
    // LSR #0, RRX, LSL #4, ASR #0, LSL #0
    logic [11:0] op2 [5] = '{12'h020, 12'h060, 12'h200, 12'h040, 12'h000};
    logic [31:0] rm  [5] = '{32'h80000001, 32'h00000003, 32'hF0000001, 32'h80000000, 32'h00001234};
    logic        c   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] eo  [5] = '{32'h00000000, 32'h80000001, 32'h00000010, 32'hFFFFFFFF, 32'h00001234};
    logic        ec  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      issue_imm(1'b0, op2[i], rm[i], c[i]);
      vec_cnt++; if (out_operand !== eo[i]) begin miss_cnt++; $display("[TB] FAIL ishift_operand[%0d] got %h exp %h", i, out_operand, eo[i]); end
      vec_cnt++; if (out_carry !== ec[i]) begin miss_cnt++; $display("[TB] FAIL ishift_carry[%0d] got %b exp %b", i, out_carry, ec[i]); end
      drain();
    end
  endtask

  task automatic test_reg_shift();
    // LSL 32, LSL 33, ROR 0x40, ROR 0, ASR 40, LSR 4
    logic [11:0] op2 [6] = '{12'h010, 12'h010, 12'h070, 12'h070, 12'h050, 12'h030};
    logic [31:0] rm  [6] = '{32'h1, 32'h1, 32'h80000000, 32'h80000000, 32'h80000000, 32'h000000F8};
    logic        c   [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [7:0]  rs  [6] = '{8'd32, 8'd33, 8'h40, 8'h00, 8'd40, 8'd4};
    logic [31:0] eo  [6] = '{32'h0, 32'h0, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'h0000000F};
    logic        ec  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    // The first request is stepped by hand so the rs_rd_en pulse and latency are visible.
    drive_req(1'b0, op2[0], rm[0], c[0]);
    vec_cnt++; if (rs_rd_en !== 1'b1) begin miss_cnt++; $display("[TB] FAIL rsrd_accept got %b exp 1", rs_rd_en); end
    tick();
    in_valid = 1'b0;
    rs_data  = rs[0];
    #1;
    vec_cnt++; if (rs_rd_en !== 1'b0) begin miss_cnt++; $display("[TB] FAIL rsrd_once got %b exp 0", rs_rd_en); end
    vec_cnt++; if (out_valid !== 1'b0) begin miss_cnt++; $display("[TB] FAIL rswait_valid got %b exp 0", out_valid); end
    vec_cnt++; if (in_ready !== 1'b0) begin miss_cnt++; $display("[TB] FAIL rswait_ready got %b exp 0", in_ready); end
    tick();
    rs_data = 8'h00;
    vec_cnt++; if (out_valid !== 1'b1) begin miss_cnt++; $display("[TB] FAIL rshift_latency got %b exp 1", out_valid); end
    vec_cnt++; if (out_operand !== eo[0]) begin miss_cnt++; $display("[TB] FAIL rshift_operand[0] got %h exp %h", out_operand, eo[0]); end
    vec_cnt++; if (out_carry !== ec[0]) begin miss_cnt++; $display("[TB] FAIL rshift_carry[0] got %b exp %b", out_carry, ec[0]); end
    drain();
    for (int i = 1; i < 6; i++) begin
      issue_reg(op2[i], rm[i], c[i], rs[i]);
      vec_cnt++; if (out_operand !== eo[i]) begin miss_cnt++; $display("[TB] FAIL rshift_operand[%0d] got %h exp %h", i, out_operand, eo[i]); end
      vec_cnt++; if (out_carry !== ec[i]) begin miss_cnt++; $display("[TB] FAIL rshift_carry[%0d] got %b exp %b", i, out_carry, ec[i]); end
      drain();
    end
  endtask

  task automatic test_back_to_back();
    issue_imm(1'b1, 12'h4FF, 32'h0, 1'b0);
    // A new request waits upstream while the result is held.
    drive_req(1'b1, 12'h0AB, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      vec_cnt++; if (out_operand !== 32'hFF000000 || out_valid !== 1'b1) begin miss_cnt++; $display("[TB] FAIL hold_stable[%0d] got %h/%b exp ff000000/1", i, out_operand, out_valid); end
      vec_cnt++; if (in_ready !== 1'b0) begin miss_cnt++; $display("[TB] FAIL hold_ready[%0d] got %b exp 0", i, in_ready); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    vec_cnt++; if (in_ready !== 1'b1) begin miss_cnt++; $display("[TB] FAIL b2b_ready got %b exp 1", in_ready); end
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    vec_cnt++; if (out_valid !== 1'b1 || out_operand !== 32'h000000AB || out_carry !== 1'b0) begin miss_cnt++; $display("[TB] FAIL b2b_result got %b/%h/%b exp 1/000000ab/0", out_valid, out_operand, out_carry); end
    // A back-to-back register shift makes out_valid drop for one cycle.
    drive_req(1'b0, 12'h010, 32'h00000003, 1'b0);
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rs_data   = 8'd1;
    #1;
    vec_cnt++; if (out_valid !== 1'b0) begin miss_cnt++; $display("[TB] FAIL b2b_rs_gap got %b exp 0", out_valid); end
    tick();
    rs_data = 8'h00;
    vec_cnt++; if (out_valid !== 1'b1 || out_operand !== 32'h00000006 || out_carry !== 1'b0) begin miss_cnt++; $display("[TB] FAIL b2b_rs_result got %b/%h/%b exp 1/00000006/0", out_valid, out_operand, out_carry); end
    drain();
  endtask

  task automatic test_reset_rswait();
    drive_req(1'b0, 12'h010, 32'h1, 1'b0);
    tick();
    in_valid = 1'b0;
    rs_data  = 8'd1;
`ifdef ARM7TDMI_OPERAND2_ICYCLE_CNT_EN
    #1;
    vec_cnt++; if (icycle_pulse !== 1'b1) begin miss_cnt++; $display("[TB] FAIL icycle_pulse got %b exp 1", icycle_pulse); end
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    vec_cnt++; if (out_valid !== 1'b0) begin miss_cnt++; $display("[TB] FAIL rst_rswait_valid got %b exp 0", out_valid); end
    vec_cnt++; if (in_ready !== 1'b1) begin miss_cnt++; $display("[TB] FAIL rst_rswait_ready got %b exp 1", in_ready); end
    tick();
    rs_data = 8'h00;
    vec_cnt++; if (out_valid !== 1'b0) begin miss_cnt++; $display("[TB] FAIL rst_no_result got %b exp 0", out_valid); end
`ifdef ARM7TDMI_OPERAND2_ICYCLE_CNT_EN
    vec_cnt++; if (icycle_cnt !== 16'd0) begin miss_cnt++; $display("[TB] FAIL icycle_rst got %0d exp 0", icycle_cnt); end
    issue_reg(12'h010, 32'h1, 1'b0, 8'd1);
    drain();
    issue_reg(12'h010, 32'h1, 1'b0, 8'd2);
    drain();
    vec_cnt++; if (icycle_cnt !== 16'd2) begin miss_cnt++; $display("[TB] FAIL icycle_cnt got %0d exp 2", icycle_cnt); end
`endif
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_imm = 1'b0; in_op2 = '0; in_rm = '0;
    in_cflag = 1'b0; rs_data = '0; out_ready = 1'b0;
    $display("[TB] starting arm7tdmi_operand2_unit bench");
    test_reset();
    test_immediate();
    test_imm_shift();
    test_reg_shift();
    test_back_to_back();
    test_reset_rswait();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
